// File: rtl/multdiv_issue_pkg.sv
// Shared definitions for the multdiv issue front end: FSM states, rstatus codes
// and the ALU-op encodings used to remember which operation is in flight.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  function automatic logic [4:0] md_aluop(input logic is_mult);
    return is_mult ? ALUOP_MUL : ALUOP_DIV;
  endfunction

  function automatic logic [31:0] md_rstatus(input logic exc, input logic is_mult);
    if (!exc) return 32'd0;
    return is_mult ? RSTATUS_MULT : RSTATUS_DIV;
  endfunction

endpackage

// File: rtl/multdiv_issue_register.sv
// Generic enabled register with asynchronous active-low clear, used for the
// operand and writeback latches.
module md_register #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         ctrl_reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) q <= '0;
    else if (en)       q <= d;
  end

endmodule

// File: rtl/multdiv_issue_wait_counter.sv
// Up counter bounding how long the front end waits on multdiv; tc flags the
// last permitted wait cycle.
module md_wait_counter #(
  parameter int               CNT_W = 7,
  parameter logic [CNT_W-1:0] TC    = '1
) (
  input  logic clock,
  input  logic ctrl_reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) count_reg <= '0;
    else if (clr)      count_reg <= '0;
    else if (en)       count_reg <= count_reg + CNT_W'(1);
  end

  assign tc = (count_reg == TC);

endmodule

// File: rtl/multdiv_issue.sv
// Execute-stage issue logic for multdiv: latches one mul/div, pulses start,
// stalls until ready or timeout, then presents a single writeback beat.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        in_valid,
  input  logic        in_is_mult,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic [31:0] wb_rstatus
);

  localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(TIMEOUT - 1);

  md_state_t   state_reg, state_next;
  logic        accept, capture, cnt_tc, is_mult_lat;
  logic [4:0]  aluop_lat, rd_lat;
  logic [31:0] cap_data, cap_rstatus;
  logic        cap_exc;

  // Gating with reset keeps stall low while reset is held.
  assign accept  = ctrl_reset_n & in_valid & (in_is_mult ^ in_is_div) & !flush
                   & (state_reg == IDLE);
  // Ready only counts in WAIT; flush beats both ready and timeout.
  assign capture = (state_reg == WAIT) & !flush & (md_resultRDY | cnt_tc);

  assign cap_data    = md_resultRDY ? md_result : 32'd0;
  assign cap_exc     = md_resultRDY ? md_exception : 1'b1;
  assign is_mult_lat = (aluop_lat == ALUOP_MUL);
  assign cap_rstatus = md_rstatus(cap_exc, is_mult_lat);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state_reg <= IDLE;
    else               state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    stall        = accept;
    case (state_reg)
      IDLE:  if (accept) state_next = START;
      START: begin
        md_ctrl_MULT = is_mult_lat & !flush;
        md_ctrl_DIV  = !is_mult_lat & !flush;
        stall        = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (capture) state_next = DONE;
      end
      DONE: begin
        wb_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      wb_valid   = 1'b0;
    end
  end

  md_wait_counter #(.CNT_W(CNT_W), .TC(WAIT_TC)) u_wait_counter (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .clr          (state_reg == START),
    .en           (state_reg == WAIT),
    .tc           (cnt_tc)
  );

  md_register #(.W(32)) u_op_a (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(accept), .d(in_opA), .q(md_operandA));
  md_register #(.W(32)) u_op_b (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(accept), .d(in_opB), .q(md_operandB));
  md_register #(.W(5))  u_rd   (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(accept), .d(in_rd), .q(rd_lat));
  md_register #(.W(5))  u_op   (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(accept), .d(md_aluop(in_is_mult)), .q(aluop_lat));

  // Writeback fields hold their values until the next completion.
  md_register #(.W(32)) u_wb_data (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(capture), .d(cap_data), .q(wb_data));
  md_register #(.W(1))  u_wb_exc  (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(capture), .d(cap_exc), .q(wb_exception));
  md_register #(.W(32)) u_wb_rs   (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(capture), .d(cap_rstatus), .q(wb_rstatus));
  md_register #(.W(5))  u_wb_rd   (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .en(capture), .d(rd_lat), .q(wb_rd));

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed plus randomized bench for multdiv_issue; the bench plays the multdiv
// unit using an arithmetic reference for results and exceptions.
module tb_multdiv_issue;

  logic        clock, ctrl_reset_n;
  logic        in_valid, in_is_mult, in_is_div, flush;
  logic [31:0] in_opA, in_opB, md_result, md_operandA, md_operandB, wb_data, wb_rstatus;
  logic [4:0]  in_rd, wb_rd;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;
  logic        stall, wb_valid, wb_exception;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  multdiv_issue #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .in_valid(in_valid), .in_is_mult(in_is_mult), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .flush(flush),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .wb_rstatus(wb_rstatus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference multdiv: signed 32x32 multiply with overflow, signed divide.
  task automatic ref_md(input logic m, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endtask

  task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input bit spurious);
    logic [31:0] r, rs;
    logic e;
    ref_md(m, a, b, r, e);
    rs = e ? (m ? 32'd4 : 32'd5) : 32'd0;
    cyc();
    in_valid = 1'b1; in_is_mult = m; in_is_div = !m;
    in_opA = a; in_opB = b; in_rd = rd;
    #1;
    chk("accept_stall", 32'(stall), 32'd1);
    chk("accept_nopulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    cyc();
    in_valid = 1'b0; in_opA = $urandom; in_opB = $urandom; in_rd = 5'($urandom);
    if (spurious) begin
      md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
    end
    #1;
    chk("pulse_mult", 32'(md_ctrl_MULT), 32'(m));
    chk("pulse_div", 32'(md_ctrl_DIV), 32'(!m));
    chk("start_stall", 32'(stall), 32'd1);
    chk("start_opA", md_operandA, a);
    chk("start_opB", md_operandB, b);
    for (int i = 1; i < k; i++) begin
      cyc();
      md_resultRDY = 1'b0; in_opA = $urandom; in_opB = $urandom;
      #1;
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
      chk("wait_opA", md_operandA, a);
      chk("wait_opB", md_operandB, b);
      chk("wait_wbv", 32'(wb_valid), 32'd0);
    end
    cyc();
    md_resultRDY = 1'b1; md_result = r; md_exception = e; in_opA = $urandom;
    #1;
    chk("rdy_stall", 32'(stall), 32'd1);
    chk("rdy_wbv", 32'(wb_valid), 32'd0);
    cyc();
    md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'b0;
    in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b0;
    #1;
    chk("done_wbv", 32'(wb_valid), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_data", wb_data, r);
    chk("done_exc", 32'(wb_exception), 32'(e));
    chk("done_rstatus", wb_rstatus, rs);
    chk("done_rd", 32'(wb_rd), 32'(rd));
    chk("done_opA", md_operandA, a);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("post_wbv", 32'(wb_valid), 32'd0);
    chk("post_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_data_hold", wb_data, r);
    $display("op m=%0d a=0x%08h b=0x%08h rd=%0d k=%0d -> data=0x%08h exc=%0d rstatus=%0d",
             m, a, b, rd, k, r, e, rs);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rm;
    ctrl_reset_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0;
    in_opA = '0; in_opB = '0; in_rd = '0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_opA", md_operandA, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rstatus", wb_rstatus, 32'd0);
    cyc();
    ctrl_reset_n = 1'b1;

    // Directed operations: plain multiply, divide by zero, multiply overflow.
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 5'd9, 32, 1'b0);
    run_op(1'b0, 32'd100, 32'd0, 5'd17, 5, 1'b1);
    run_op(1'b1, 32'h4000_0000, 32'd4, 5'd3, 3, 1'b1);
    run_op(1'b0, 32'hFFFF_FF9C, 32'd7, 5'd31, 1, 1'b0);

    // Illegal mult+div encoding is not accepted.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b1;
    #1;
    chk("illegal_stall", 32'(stall), 32'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("illegal_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);

    // Flush together with a would-be accept.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b0; in_is_div = 1'b1; flush = 1'b1;
    #1;
    chk("flush_acc_stall", 32'(stall), 32'd0);
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_acc_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("flush_acc_stall2", 32'(stall), 32'd0);

    // Flush during START gates the pulse.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b0; in_opA = 32'd2; in_opB = 32'd3;
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_start_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_start_idle", 32'(stall), 32'd0);

    // Flush mid-WAIT, then a late ready must not write back.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b0; in_is_div = 1'b1; in_opA = 32'd50; in_opB = 32'd5;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; md_resultRDY = 1'b1; md_result = 32'h1234_5678;
    #1;
    chk("flush_wait_stall", 32'(stall), 32'd0);
    chk("flush_wait_wbv", 32'(wb_valid), 32'd0);
    cyc();
    md_resultRDY = 1'b0;
    #1;
    chk("flush_late_wbv", 32'(wb_valid), 32'd0);
    chk("flush_data_hold", wb_data, 32'hFFFF_FFF2);

    // Timeout: ready never arrives.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b0;
    in_opA = 32'd5; in_opB = 32'd6; in_rd = 5'd3;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("to_pulse", 32'(md_ctrl_MULT), 32'd1);
    for (int i = 0; i < 64; i++) begin
      cyc();
      #1;
      chk("to_wait_stall", 32'(stall), 32'd1);
      chk("to_wait_wbv", 32'(wb_valid), 32'd0);
    end
    cyc();
    #1;
    chk("to_wbv", 32'(wb_valid), 32'd1);
    chk("to_data", wb_data, 32'd0);
    chk("to_exc", 32'(wb_exception), 32'd1);
    chk("to_rstatus", wb_rstatus, 32'd4);
    chk("to_rd", 32'(wb_rd), 32'd3);
    $display("timeout op rd=3 -> exc=1 rstatus=4");

    // Asynchronous reset in the middle of WAIT.
    cyc();
    in_valid = 1'b1; in_is_mult = 1'b0; in_is_div = 1'b1;
    in_opA = 32'd77; in_opB = 32'd7; in_rd = 5'd12;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("arst_opA", md_operandA, 32'd0);
    chk("arst_opB", md_operandB, 32'd0);
    chk("arst_exc", 32'(wb_exception), 32'd0);
    chk("arst_rstatus", wb_rstatus, 32'd0);
    chk("arst_rd", 32'(wb_rd), 32'd0);
    cyc();
    cyc();
    ctrl_reset_n = 1'b1;
    md_resultRDY = 1'b1; md_result = 32'hCAFE_0000;
    cyc();
    #1;
    chk("arst_idle_stall", 32'(stall), 32'd0);
    chk("arst_idle_wbv", 32'(wb_valid), 32'd0);
    md_resultRDY = 1'b0;

    // Randomized operations against the reference.
    for (int n = 0; n < 8; n++) begin
      rm = 1'($urandom_range(0, 1));
      if (n % 2 == 0) begin
        ra = 32'($urandom_range(0, 2000)) - 32'd1000;
        rb = 32'($urandom_range(0, 2000)) - 32'd1000;
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      if (n % 3 == 0) rb = 32'd0;
      run_op(rm, ra, rb, 5'($urandom), $urandom_range(1, 10), 1'(n % 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
